// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter and sequencer for a shared 2:1 data mux.
//
// Two requesters (A, B) each present req/data/last. One owner at a time holds
// the mux. An owner is released when it withdraws its request, ends its burst,
// or has used up its hold budget while the other side is waiting. On release
// the waiting side is granted directly, so no idle cycle is inserted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_a, data_a, last_a   requester A: request, word, end-of-burst
//   req_b, data_b, last_b   requester B: request, word, end-of-burst
//   gnt_a, gnt_b            registered grants, never both high
//   sel                     mux select, 1 = data_a, equals gnt_a
//   out_data, out_valid     registered muxed word and its qualifier
module mux2_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              last_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              last_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int unsigned      HoldW    = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD);

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;  // 0: A wins the next tie, 1: B wins
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  // Owner-relative view of the current state
  logic              owned, own_req, own_last, other_req;
  logic [DATA_W-1:0] own_data;
  logic              xfer, rel_own, grant_a, grant_b;

  always_comb begin
    owned     = 1'b0;
    own_req   = 1'b0;
    own_last  = 1'b0;
    other_req = 1'b0;
    own_data  = '0;
    unique case (state_q)
      StOwnA: begin
        owned     = 1'b1;
        own_req   = req_a;
        own_last  = last_a;
        other_req = req_b;
        own_data  = data_a;
      end
      StOwnB: begin
        owned     = 1'b1;
        own_req   = req_b;
        own_last  = last_b;
        other_req = req_a;
        own_data  = data_b;
      end
      default: ;
    endcase

    xfer = owned & own_req;
    // >= rather than == so a saturated counter preempts on the first
    // transfer after the other side starts requesting.
    rel_own = owned & (~own_req | own_last | ((hold_q >= HoldLast) & other_req));

    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          grant_a = ~prio_q;
          grant_b = prio_q;
        end else begin
          grant_a = req_a;
          grant_b = req_b;
        end
      end
      StOwnA: begin
        // Waiting side takes over directly; otherwise the owner re-arms
        // (only possible when it still requests).
        if (rel_own) begin
          if (req_b) grant_b = 1'b1;
          else       grant_a = req_a;
        end
      end
      StOwnB: begin
        if (rel_own) begin
          if (req_a) grant_a = 1'b1;
          else       grant_b = req_b;
        end
      end
      default: ;
    endcase

    state_d = state_q;
    prio_d  = prio_q;
    hold_d  = hold_q;
    if (grant_a) begin
      state_d = StOwnA;
      prio_d  = 1'b1;
      hold_d  = '0;
    end else if (grant_b) begin
      state_d = StOwnB;
      prio_d  = 1'b0;
      hold_d  = '0;
    end else if (rel_own || (state_q != StOwnA && state_q != StOwnB)) begin
      // Also recovers the unused encoding
      state_d = StIdle;
      hold_d  = '0;
    end else if (xfer && (hold_q != HoldMax)) begin
      hold_d = hold_q + HoldW'(1);
    end

    out_valid_d = xfer;
    out_data_d  = xfer ? own_data : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt_a     = (state_q == StOwnA);
  assign gnt_b     = (state_q == StOwnB);
  assign sel       = gnt_a;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter (DATA_W=8, MAX_HOLD=4): per-cycle vector table with
// hand-derived expectations queued at drive time and checked after the edge,
// plus hand-written reset/tie sequences.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       gnt_a, gnt_b, sel, out_valid;
  logic [7:0] out_data;

  mux2_arbiter #(
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .data_a   (data_a),
    .last_a   (last_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .last_b   (last_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ra, la, rb, lb;
    logic [7:0] da, db;
    bit         ga, gb, v;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    bit         ga, gb, v;
    logic [7:0] d;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(bit ra, logic [7:0] da, bit la, bit rb, logic [7:0] db, bit lb,
                              bit ga, bit gb, bit v, logic [7:0] d);
    vec_t r;
    r.ra = ra; r.da = da; r.la = la;
    r.rb = rb; r.db = db; r.lb = lb;
    r.ga = ga; r.gb = gb; r.v = v; r.d = d;
    return r;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, id, got, want);
    end
  endtask

  task automatic chk_reset(input int id);
    chk("rst_gnt_a", id, 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", id, 32'(gnt_b), 32'd0);
    chk("rst_sel", id, 32'(sel), 32'd0);
    chk("rst_valid", id, 32'(out_valid), 32'd0);
    chk("rst_data", id, 32'(out_data), 32'd0);
  endtask

  // Drive on the falling edge, expect after the next rising edge
  task automatic step(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    req_a = v.ra; data_a = v.da; last_a = v.la;
    req_b = v.rb; data_b = v.db; last_b = v.lb;
    e.ga = v.ga; e.gb = v.gb; e.v = v.v; e.d = v.d; e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt_a", e.id, 32'(gnt_a), 32'(e.ga));
    chk("gnt_b", e.id, 32'(gnt_b), 32'(e.gb));
    chk("sel", e.id, 32'(sel), 32'(e.ga));
    chk("out_valid", e.id, 32'(out_valid), 32'(e.v));
    if (e.v) chk("out_data", e.id, 32'(out_data), 32'(e.d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Single burst 11,22,33 (last on 33), then withdraw
    vecs.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 0, 1, 8'h11));
    vecs.push_back(mk(1, 8'h22, 0, 0, 8'h00, 0, 1, 0, 1, 8'h22));
    vecs.push_back(mk(1, 8'h33, 1, 0, 8'h00, 0, 1, 0, 1, 8'h33));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // Tie with prio=B, then preemption every 4 transfers
    vecs.push_back(mk(1, 8'hA1, 0, 1, 8'hB1, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'hA1, 0, 1, 8'hB1, 0, 0, 1, 1, 8'hB1));
    vecs.push_back(mk(1, 8'hA1, 0, 1, 8'hB2, 0, 0, 1, 1, 8'hB2));
    vecs.push_back(mk(1, 8'hA1, 0, 1, 8'hB3, 0, 0, 1, 1, 8'hB3));
    vecs.push_back(mk(1, 8'hA1, 0, 1, 8'hB4, 0, 1, 0, 1, 8'hB4));
    vecs.push_back(mk(1, 8'hA1, 0, 1, 8'hB5, 0, 1, 0, 1, 8'hA1));
    vecs.push_back(mk(1, 8'hA2, 0, 1, 8'hB5, 0, 1, 0, 1, 8'hA2));
    vecs.push_back(mk(1, 8'hA3, 0, 1, 8'hB5, 0, 1, 0, 1, 8'hA3));
    vecs.push_back(mk(1, 8'hA4, 0, 1, 8'hB5, 0, 0, 1, 1, 8'hA4));
    vecs.push_back(mk(1, 8'hA5, 0, 1, 8'hB5, 0, 0, 1, 1, 8'hB5));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // Hold saturation: 10 transfers from A alone, then B preempts at once
    vecs.push_back(mk(1, 8'hC0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1, 8'hC0 + 8'(i), 0, 0, 8'h00, 0, 1, 0, 1, 8'hC0 + 8'(i)));
    end
    vecs.push_back(mk(1, 8'hCA, 0, 1, 8'hD0, 0, 0, 1, 1, 8'hCA));
    vecs.push_back(mk(0, 8'h00, 0, 1, 8'hD0, 1, 0, 1, 1, 8'hD0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // Withdraw after 2 words
    vecs.push_back(mk(1, 8'hE1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'hE1, 0, 0, 8'h00, 0, 1, 0, 1, 8'hE1));
    vecs.push_back(mk(1, 8'hE2, 0, 0, 8'h00, 0, 1, 0, 1, 8'hE2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // Tie (prio=B), then last and preemption on the same transfer
    vecs.push_back(mk(1, 8'hA7, 0, 1, 8'hF1, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'hA7, 0, 1, 8'hF1, 0, 0, 1, 1, 8'hF1));
    vecs.push_back(mk(1, 8'hA7, 0, 1, 8'hF2, 0, 0, 1, 1, 8'hF2));
    vecs.push_back(mk(1, 8'hA7, 0, 1, 8'hF3, 0, 0, 1, 1, 8'hF3));
    vecs.push_back(mk(1, 8'hA7, 0, 1, 8'hF4, 1, 1, 0, 1, 8'hF4));
    vecs.push_back(mk(1, 8'hA7, 1, 0, 8'h00, 0, 1, 0, 1, 8'hA7));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));

    repeat (2) @(posedge clk);
    #1;
    chk_reset(-1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i], i);

    // Reset during B's second transfer: outputs clear without a clock edge
    step(mk(0, 8'h00, 0, 1, 8'h91, 0, 0, 1, 0, 8'h00), 100);
    step(mk(0, 8'h00, 0, 1, 8'h91, 0, 0, 1, 1, 8'h91), 101);
    @(negedge clk);
    data_b = 8'h92;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(102);
    req_b = 1'b0;
    @(posedge clk);
    #1;
    chk_reset(103);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset goes to A; a repeated tie goes to B; handover B->A
    // keeps out_valid continuous
    step(mk(1, 8'h51, 0, 1, 8'h61, 0, 1, 0, 0, 8'h00), 200);
    step(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00), 201);
    step(mk(1, 8'h81, 0, 1, 8'h71, 0, 0, 1, 0, 8'h00), 202);
    step(mk(1, 8'h81, 0, 1, 8'h71, 0, 0, 1, 1, 8'h71), 203);
    step(mk(1, 8'h81, 0, 1, 8'h72, 1, 1, 0, 1, 8'h72), 204);
    step(mk(1, 8'h81, 0, 0, 8'h00, 0, 1, 0, 1, 8'h81), 205);
    step(mk(1, 8'h82, 1, 0, 8'h00, 0, 1, 0, 1, 8'h82), 206);
    step(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00), 207);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester arbiter and sequencer for the shared 2:1 multiplexer datapath (mux21b select convention). Requesters A and B each present a request, data and an end-of-burst flag. The block grants the mux to one requester at a time using round-robin priority and a bounded hold time. It drives the mux select and a registered, qualified output stream. It sits between the two producers and the single shared consumer of the muxed word.

## Interface
Parameters:
- DATA_W, 8, width of data_a, data_b and out_data.
- MAX_HOLD, 4, maximum transfer cycles per grant while the other side is requesting; legal range ≥ 1.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A wants / is transferring.
- data_a  input  DATA_W  requester A word.
- last_a  input  1  A's current word is the final word of its burst; qualified by req_a.
- req_b  input  1  requester B request.
- data_b  input  DATA_W  requester B word.
- last_b  input  1  B end-of-burst.
- gnt_a  output  1  A owns the mux (registered).
- gnt_b  output  1  B owns the mux (registered).
- sel  output  1  mux select: 1 = data_a, 0 = data_b (registered, equals gnt_a).
- out_data  output  DATA_W  registered muxed word.
- out_valid  output  1  out_data holds a transferred word this cycle.

## Operation
- States: IDLE, OWN_A, OWN_B. gnt_a=1 only in OWN_A; gnt_b=1 only in OWN_B; never both.
- Transfer cycle: the owner's req is high in its OWN state. Each transfer captures the owner's data into out_data.
- Round-robin pointer `prio`: the requester to win the next tie. It flips to the other side whenever a grant is issued.
- IDLE transitions:
  - Only req_a high: go to OWN_A.
  - Only req_b high: go to OWN_B.
  - Both high: go to OWN_prio.
  - Neither high: stay in IDLE.
- hold_cnt: width $clog2(MAX_HOLD+1). It clears on entering any OWN state and increments on each transfer.
- Release from OWN_x occurs at the end of a cycle when any of the following holds:
  - req_x is low (owner withdrew; no transfer this cycle).
  - Transfer with last_x=1.
  - Transfer with hold_cnt == MAX_HOLD-1 while the other requester's req is high (preemption).
- Hold limit with the other side idle: the owner keeps the grant and hold_cnt saturates at MAX_HOLD.
- Next state on release:
  - Other req high: go directly to OWN_other, with no IDLE bubble.
  - Otherwise, owner's req still high after a last/hold release: re-enter OWN_x with hold_cnt cleared.
  - Otherwise: go to IDLE.
- Simultaneous last_x and preemption on the same cycle: a single release; the next owner follows the rule above.
- Reset values (rst_n low, any time):
  - State IDLE; gnt_a=gnt_b=0; sel=0.
  - out_data=0; out_valid=0.
  - hold_cnt=0; prio=A.
- Reset mid-burst: all partial-burst state is discarded. The first grant after reset follows the IDLE rules with prio=A.

## Timing
- Request latency: req seen high in IDLE at edge N gives gnt at N+1, so the first transfer is possible in cycle N+1.
- Output latency: a transfer at edge N gives out_valid=1 and out_data = owner's data sampled at N, both during cycle N+1.
- out_valid is low in any cycle that follows a non-transfer cycle.
- Handover: the final transfer of A at edge N gives gnt_a=0 and gnt_b=1 at N+1. B's first word appears on out_data at N+2. Back-to-back out_valid holds across the handover.
- Throughput: one word per clock while any requester holds req.
- sel changes only on clock edges, coincident with the gnt outputs.
- Requesters hold data and last stable while req is high and gnt is low. Data not accepted in a cycle is not consumed.

## Test plan
- Reset: assert rst_n=0 mid-simulation → all outputs 0 asynchronously, before the next clk edge.
- Single burst: req_a=1, data_a=0x11,0x22,0x33 with last_a on 0x33, req_b=0 → gnt_a 1 cycle after req; out_data 0x11,0x22,0x33 on 3 consecutive out_valid cycles; IDLE after; gnt_a=0.
- Tie from reset: req_a=req_b=1 same cycle → OWN_A first; B granted immediately after A's last with no gap in out_valid. A repeated tie → B wins.
- Preemption: MAX_HOLD=4, both requesting continuously, no last → grants alternate A,B,A,B every 4 transfers, each with exactly 4 out_valid words.
- Hold saturation: req_a held 10 cycles with no last, req_b=0 → gnt_a stays 1, 10 consecutive out_valid. Raising req_b then gives a handover within ≤1 transfer (hold_cnt already ≥ MAX_HOLD-1).
- Withdraw/reset mid-burst: in OWN_A, drop req_a after 2 words → out_valid low next cycle, IDLE. Asserting rst_n=0 during OWN_B word 2 → gnt_b=0 and out_valid=0 immediately; after release, a tie grants A.
